lcd_text_buffer: RTL

LCD_TEXT_BUFFER -- requirements
Module: lcd_text_buffer

---
 rtl/lcd_text_buffer_if.sv | 23 ++
 rtl/lcd_text_buffer.sv | 114 +++++++++++
 2 files changed

// File: rtl/lcd_text_buffer_if.sv
// rtl/lcd_text_buffer_if.sv - write stream, cell read port and status of the LCD text buffer
interface lcd_text_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       set_pos;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       dirty;
  logic       dirty_ack;
  logic [4:0] cursor;
  logic       busy;

  modport master (
    output wr_valid, wr_data, set_pos, rd_addr, dirty_ack,
    input  wr_ready, rd_data, dirty, cursor, busy
  );

  modport slave (
    input  wr_valid, wr_data, set_pos, rd_addr, dirty_ack,
    output wr_ready, rd_data, dirty, cursor, busy
  );
endinterface

// File: rtl/lcd_text_buffer.sv
// rtl/lcd_text_buffer.sv - 2x16 character buffer with cursor, control bytes and clear sequencer
module lcd_text_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                clk,
  input  logic                rst,
  lcd_text_buffer_if.slave    bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state_q;
  logic [4:0] cursor_q, cursor_d;
  logic [4:0] clr_idx_q;
  logic       dirty_q, dirty_d;
  logic       busy_q, wr_ready_q;
  logic [7:0] rd_data_q;
  logic [7:0] mem_q [32];

  logic       xfer, we, go_clear, clr_last;
  logic [4:0] waddr;
  logic [7:0] wdata;

  assign xfer     = bus.wr_valid && wr_ready_q;
  assign clr_last = (state_q == CLEAR) && (clr_idx_q == 5'd31);

  always_comb begin
    cursor_d = cursor_q;
    we       = 1'b0;
    waddr    = cursor_q;
    wdata    = bus.wr_data;
    go_clear = 1'b0;
    if (state_q == CLEAR) begin
      we    = 1'b1;
      waddr = clr_idx_q;
      wdata = FILL_CHAR;
    end else if (xfer) begin
      if (bus.set_pos) begin
        cursor_d = bus.wr_data[4:0];
      end else if (bus.wr_data >= 8'h20) begin
        we       = 1'b1;
        cursor_d = cursor_q + 5'd1;
      end else begin
        case (bus.wr_data)
          8'h0D:   cursor_d = {cursor_q[4], 4'b0000};
          8'h0A:   cursor_d = {~cursor_q[4], cursor_q[3:0]};
          8'h08:   cursor_d = cursor_q - 5'd1;
          8'h0C: begin
            cursor_d = 5'd0;
            go_clear = 1'b1;
          end
          default: cursor_d = cursor_q;
        endcase
      end
    end
  end

  // A set condition on the same edge as dirty_ack keeps the refresh request alive.
  always_comb begin
    dirty_d = dirty_q;
    if ((we && (state_q == IDLE)) || clr_last)
      dirty_d = 1'b1;
    else if (bus.dirty_ack)
      dirty_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CLEAR;
      clr_idx_q  <= 5'd0;
      busy_q     <= 1'b1;
      wr_ready_q <= 1'b0;
      cursor_q   <= 5'd0;
      dirty_q    <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      cursor_q  <= cursor_d;
      dirty_q   <= dirty_d;
      rd_data_q <= mem_q[bus.rd_addr];
      case (state_q)
        IDLE: begin
          if (go_clear) begin
            state_q    <= CLEAR;
            clr_idx_q  <= 5'd0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
          end
        end
        CLEAR: begin
          clr_idx_q <= clr_idx_q + 5'd1;
          if (clr_last) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Cell storage has no reset; the clear sequence initialises it after every reset.
  always_ff @(posedge clk) begin
    if (we)
      mem_q[waddr] <= wdata;
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.busy     = busy_q;
  assign bus.cursor   = cursor_q;
  assign bus.dirty    = dirty_q;
  assign bus.rd_data  = rd_data_q;

endmodule
